// File: rtl/regfile_scoreboard.sv
// Register file with same-cycle write-back bypass and a per-register pending-write
// scoreboard, so the hazard unit can detect RAW/WAW hazards from this block alone.
`ifndef STAK_ADDRESS
`define STAK_ADDRESS 32'h0000_1000
`endif
`ifndef MMIO_ADDRESS
`define MMIO_ADDRESS 32'hFFFF_0000
`endif

module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    parameter int NUM_READ = 2,
    parameter int CNT_W    = 2,
    parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(`STAK_ADDRESS),
    parameter logic [DATA_W-1:0] TOP_INIT = DATA_W'(`MMIO_ADDRESS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         iss_en,
    input  logic [ADDR_W-1:0]            iss_addr,
    output logic                         iss_ready,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    output logic                         sb_err
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [CNT_W-1:0]  r_cnt  [NUM_REGS];
    logic              r_sb_err;

    logic w_wb_act;
    logic w_iss_full;
    logic w_iss_ready;
    logic w_iss_acc;

    assign w_wb_act    = wb_en && (wb_addr != '0);
    assign w_iss_full  = (r_cnt[iss_addr] == {CNT_W{1'b1}});
    // A full counter can still take an issue when a write-back to the same
    // register frees a slot in the same cycle.
    assign w_iss_ready = (iss_addr == '0) || !w_iss_full || (wb_en && (wb_addr == iss_addr));
    assign w_iss_acc   = iss_en && w_iss_ready && !reset && (iss_addr != '0);

    assign iss_ready = reset ? 1'b1 : w_iss_ready;
    assign sb_err    = r_sb_err;

    genvar g;
    generate
        for (g = 0; g < NUM_READ; g++) begin : g_rd
            logic [ADDR_W-1:0] w_a;
            logic              w_hit;
            assign w_a   = rd_addr[g*ADDR_W +: ADDR_W];
            assign w_hit = w_wb_act && (wb_addr == w_a) && !reset;
            assign rd_data[g*DATA_W +: DATA_W] = (w_a == '0) ? '0 :
                                                 w_hit ? wb_data : r_regs[w_a];
            // Busy after this cycle's release; an underflowing release leaves 0.
            assign rd_busy[g] = (w_a != '0) && !reset &&
                                (w_hit ? (r_cnt[w_a] > CNT_W'(1)) : (r_cnt[w_a] != '0));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == 2)
                    r_regs[i] <= SP_INIT;
                else if (i == NUM_REGS - 1)
                    r_regs[i] <= TOP_INIT;
                else
                    r_regs[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            if (w_wb_act)
                r_regs[wb_addr] <= wb_data;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_iss_acc && (iss_addr == ADDR_W'(r)) &&
                    !(w_wb_act && (wb_addr == ADDR_W'(r)))) begin
                    r_cnt[r] <= r_cnt[r] + CNT_W'(1);
                end else if (w_wb_act && (wb_addr == ADDR_W'(r)) &&
                             !(w_iss_acc && (iss_addr == ADDR_W'(r)))) begin
                    if (r_cnt[r] != '0)
                        r_cnt[r] <= r_cnt[r] - CNT_W'(1);
                    else
                        r_sb_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: the driver pushes hand-computed
// expectations into a queue and a negedge monitor pops and compares them.
module tb_regfile_scoreboard;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_READ = 2;
    localparam int CNT_W    = 2;
    localparam logic [31:0] SP  = 32'h0000_8000;
    localparam logic [31:0] TOP = 32'hF000_0000;
    localparam int EXP_W = 2 * DATA_W + NUM_READ + 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_READ*ADDR_W-1:0] rd_addr;
    logic [NUM_READ*DATA_W-1:0] rd_data;
    logic [NUM_READ-1:0]        rd_busy;
    logic                       iss_en;
    logic [ADDR_W-1:0]          iss_addr;
    logic                       iss_ready;
    logic                       wb_en;
    logic [ADDR_W-1:0]          wb_addr;
    logic [DATA_W-1:0]          wb_data;
    logic                       sb_err;

    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;

    regfile_scoreboard #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_READ(NUM_READ),
        .CNT_W(CNT_W), .SP_INIT(SP), .TOP_INIT(TOP)
    ) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .iss_en(iss_en), .iss_addr(iss_addr),
        .iss_ready(iss_ready), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .sb_err(sb_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] a0, input logic [4:0] a1,
                          input logic ie, input logic [4:0] ia,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd);
        rd_addr  = {a1, a0};
        iss_en   = ie;
        iss_addr = ia;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
    endtask

    task automatic chk(input string name, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] busy, input logic rdy, input logic err);
        exp_q.push_back({d0, d1, busy, rdy, err});
        name_q.push_back(name);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [EXP_W-1:0] e;
            logic [EXP_W-1:0] a;
            string            n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {rd_data[31:0], rd_data[63:32], rd_busy, iss_ready, sb_err};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got d0=%h d1=%h busy=%b rdy=%b err=%b, want d0=%h d1=%h busy=%b rdy=%b err=%b",
                         n, a[67:36], a[35:4], a[3:2], a[1], a[0],
                         e[67:36], e[35:4], e[3:2], e[1], e[0]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        set_in(5'd2, 5'd31, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        #2;
        chk("in_reset", SP, TOP, 2'b00, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        cyc(); chk("reset_vals", SP, TOP, 2'b00, 1'b1, 1'b0);

        // bypass on reg 5 (issued first so the write-back is legitimate)
        cyc(); set_in(5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0);
        chk("iss5", 32'h0, SP, 2'b00, 1'b1, 1'b0);
        cyc(); set_in(5'd5, 5'd2, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        chk("bypass5", 32'hDEADBEEF, SP, 2'b00, 1'b1, 1'b0);
        cyc(); set_in(5'd5, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("persist5", 32'hDEADBEEF, SP, 2'b00, 1'b1, 1'b0);

        // fill reg 7's counter to 3, stall, issue with simultaneous wb, drain
        cyc(); set_in(5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
        chk("iss7_a", 32'h0, SP, 2'b00, 1'b1, 1'b0);
        cyc(); chk("iss7_b", 32'h0, SP, 2'b01, 1'b1, 1'b0);
        cyc(); chk("iss7_c", 32'h0, SP, 2'b01, 1'b1, 1'b0);
        cyc(); chk("iss7_full", 32'h0, SP, 2'b01, 1'b0, 1'b0);
        cyc(); set_in(5'd7, 5'd2, 1'b1, 5'd7, 1'b1, 5'd7, 32'h70);
        chk("iss7_with_wb", 32'h70, SP, 2'b01, 1'b1, 1'b0);
        cyc(); set_in(5'd7, 5'd2, 1'b0, 5'd7, 1'b0, 5'd0, 32'h0);
        chk("cnt7_held3", 32'h70, SP, 2'b01, 1'b0, 1'b0);
        cyc(); set_in(5'd7, 5'd2, 1'b0, 5'd7, 1'b1, 5'd7, 32'h71);
        chk("wb7_1", 32'h71, SP, 2'b01, 1'b1, 1'b0);
        cyc(); set_in(5'd7, 5'd2, 1'b0, 5'd7, 1'b1, 5'd7, 32'h72);
        chk("wb7_2", 32'h72, SP, 2'b01, 1'b1, 1'b0);
        cyc(); set_in(5'd7, 5'd2, 1'b0, 5'd7, 1'b1, 5'd7, 32'h73);
        chk("wb7_last", 32'h73, SP, 2'b00, 1'b1, 1'b0);
        cyc(); set_in(5'd7, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("idle7", 32'h73, SP, 2'b00, 1'b1, 1'b0);

        // register 0 ignores write-back entirely
        cyc(); set_in(5'd0, 5'd2, 1'b0, 5'd0, 1'b1, 5'd0, 32'h1234);
        chk("wb0", 32'h0, SP, 2'b00, 1'b1, 1'b0);
        cyc(); set_in(5'd0, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("after_wb0", 32'h0, SP, 2'b00, 1'b1, 1'b0);

        // simultaneous issue and write-back from cnt 0: no underflow
        cyc(); set_in(5'd4, 5'd2, 1'b1, 5'd4, 1'b1, 5'd4, 32'h44);
        chk("iss_wb4", 32'h44, SP, 2'b00, 1'b1, 1'b0);
        cyc(); set_in(5'd4, 5'd2, 1'b0, 5'd4, 1'b0, 5'd0, 32'h0);
        chk("after4", 32'h44, SP, 2'b00, 1'b1, 1'b0);

        // underflow on reg 9: data lands, sticky error
        cyc(); set_in(5'd9, 5'd2, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99);
        chk("wb9_under", 32'h99, SP, 2'b00, 1'b1, 1'b0);
        cyc(); set_in(5'd9, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("err_set", 32'h99, SP, 2'b00, 1'b1, 1'b1);
        cyc(); chk("err_sticky", 32'h99, SP, 2'b00, 1'b1, 1'b1);

        // async reset mid-sequence on reg 3
        cyc(); set_in(5'd3, 5'd2, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0);
        chk("iss3_a", 32'h0, SP, 2'b00, 1'b1, 1'b1);
        cyc(); chk("iss3_b", 32'h0, SP, 2'b01, 1'b1, 1'b1);
        cyc(); set_in(5'd3, 5'd2, 1'b0, 5'd3, 1'b0, 5'd0, 32'h0);
        chk("pre_reset", 32'h0, SP, 2'b01, 1'b1, 1'b1);
        cyc(); set_in(5'd3, 5'd2, 1'b1, 5'd3, 1'b1, 5'd3, 32'h33);
        #1 reset = 1'b1;
        chk("async_reset", 32'h0, SP, 2'b00, 1'b1, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        set_in(5'd3, 5'd31, 1'b0, 5'd3, 1'b0, 5'd0, 32'h0);
        chk("no_partial_write", 32'h0, TOP, 2'b00, 1'b1, 1'b0);
        cyc(); set_in(5'd9, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        chk("reg9_cleared", 32'h0, SP, 2'b00, 1'b1, 1'b0);

        cyc();
        cyc();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
